// File: rtl/aes128_decrypt.sv
// rtl/aes128_decrypt.sv - Iterative AES-128 inverse cipher, one round per clock
//
// Derives rk10 by forward key expansion, then runs the inverse rounds while
// unwinding the key schedule one step per round, so no round-key store exists.
// Byte 0 is bits [127:120]; the state is column-major (byte i = row i%4, col i/4).
//
// Ports:
//   clk        in   1    rising-edge clock
//   rst        in   1    asynchronous active-high reset
//   start      in   1    request pulse, sampled only in IDLE
//   ciphertext in   128  block to decrypt, sampled with start
//   key        in   128  cipher key, sampled with start
//   plaintext  out  128  result, valid with done, held until next completion
//   busy       out  1    operation in progress
//   done       out  1    one-cycle completion pulse
module aes128_decrypt (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  output logic [127:0] plaintext,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, KEXP, ADDK, DEC} state_t;

  state_t       state_q, state_d;
  logic [127:0] ct_q, ct_d, key_q, key_d, st_q, st_d, pt_q, pt_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         busy_q, busy_d, done_q, done_d;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 via an addition chain; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240;
    a2   = gf_mul(a, a);
    a3   = gf_mul(a2, a);
    a6   = gf_mul(a3, a3);
    a12  = gf_mul(a6, a6);
    a15  = gf_mul(a12, a3);
    a30  = gf_mul(a15, a15);
    a60  = gf_mul(a30, a30);
    a120 = gf_mul(a60, a60);
    a240 = gf_mul(a120, a120);
    return gf_mul(gf_mul(a240, a12), a2);
  endfunction

  function automatic logic [7:0] aes_sbox(input logic [7:0] a);
    logic [7:0] x;
    x = gf_inv(a);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] aes_inv_sbox(input logic [7:0] a);
    return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {aes_sbox(w[23:16]), aes_sbox(w[15:8]), aes_sbox(w[7:0]), aes_sbox(w[31:24])};
  endfunction

  // InvShiftRows moves row r right by r columns; InvSubBytes folded into the same pass.
  function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = aes_inv_sbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   x1 [4];
    logic [7:0]   x2 [4];
    logic [7:0]   x4 [4];
    logic [7:0]   x8 [4];
    logic [7:0]   m9 [4];
    logic [7:0]   m11 [4];
    logic [7:0]   m13 [4];
    logic [7:0]   m14 [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        x1[r]  = s[127-8*(r+4*c) -: 8];
        x2[r]  = xtime(x1[r]);
        x4[r]  = xtime(x2[r]);
        x8[r]  = xtime(x4[r]);
        m9[r]  = x8[r] ^ x1[r];
        m11[r] = x8[r] ^ x2[r] ^ x1[r];
        m13[r] = x8[r] ^ x4[r] ^ x1[r];
        m14[r] = x8[r] ^ x4[r] ^ x2[r];
      end
      o[127-32*c -: 32] = {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
                           m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
                           m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
                           m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
    end
    return o;
  endfunction

  // One SubWord(RotWord()) unit serves both directions: forward expansion
  // feeds it w3, the unwinding step feeds it the recovered w3 = w7 ^ w6.
  logic [31:0]  sw_in, sw_out;
  logic [7:0]   rc;
  logic [127:0] key_fwd, key_inv, sub_x;
  logic [31:0]  f0, f1, f2;

  assign sw_in  = (state_q == KEXP) ? key_q[31:0] : (key_q[63:32] ^ key_q[31:0]);
  assign sw_out = sub_rot_word(sw_in);
  assign rc     = (state_q == ADDK) ? 8'h36 : rcon(rnd_q);

  assign f0      = key_q[127:96] ^ sw_out ^ {rc, 24'h0};
  assign f1      = key_q[95:64] ^ f0;
  assign f2      = key_q[63:32] ^ f1;
  assign key_fwd = {f0, f1, f2, key_q[31:0] ^ f2};

  assign key_inv = {key_q[127:96] ^ sw_out ^ {rc, 24'h0},
                    key_q[95:64] ^ key_q[127:96],
                    key_q[63:32] ^ key_q[95:64],
                    key_q[31:0]  ^ key_q[63:32]};

  assign sub_x = inv_sub_shift(st_q) ^ key_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ct_q    <= '0;
      key_q   <= '0;
      st_q    <= '0;
      pt_q    <= '0;
      rnd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ct_q    <= ct_d;
      key_q   <= key_d;
      st_q    <= st_d;
      pt_q    <= pt_d;
      rnd_q   <= rnd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = KEXP;
      KEXP:    if (rnd_q == 4'd10) state_d = ADDK;
      ADDK:    state_d = DEC;
      DEC:     if (rnd_q == 4'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ct_d   = ct_q;
    key_d  = key_q;
    st_d   = st_q;
    pt_d   = pt_q;
    rnd_d  = rnd_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          ct_d   = ciphertext;
          key_d  = key;
          rnd_d  = 4'd1;
          busy_d = 1'b1;
        end
      end
      KEXP: begin
        key_d = key_fwd;
        rnd_d = rnd_q + 4'd1;
      end
      ADDK: begin
        st_d  = ct_q ^ key_q;
        key_d = key_inv;
        rnd_d = 4'd9;
      end
      DEC: begin
        if (rnd_q != 4'd0) begin
          st_d  = inv_mix_columns(sub_x);
          key_d = key_inv;
          rnd_d = rnd_q - 4'd1;
        end else begin
          pt_d   = sub_x;
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign plaintext = pt_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_aes128_decrypt.sv
// tb/tb_aes128_decrypt.sv - Scoreboard bench for aes128_decrypt
module tb_aes128_decrypt;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] ciphertext = '0;
  logic [127:0] key = '0;
  logic [127:0] plaintext;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  aes128_decrypt dut (
    .clk(clk), .rst(rst), .start(start), .ciphertext(ciphertext), .key(key),
    .plaintext(plaintext), .busy(busy), .done(done)
  );

  localparam logic [127:0] C1_K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] E_CT  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] E_PT  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] L_K   = 128'h436f64696e672049732046756e212121;
  localparam logic [127:0] L_PT  = 128'h48656c6c6f20576f726c642121212121;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done = 0;
  logic done_prev = 1'b0;
  logic [127:0] exp_q[$];
  int acc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference encryptor used only to build the loopback ciphertext.
  function automatic logic [7:0] t_xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] t_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 0; aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = t_xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] t_sbox(input logic [7:0] a);
    logic [7:0] x;
    x = 8'h00;
    for (int b = 1; b < 256; b++)
      if (t_mul(a, 8'(b)) == 8'h01) x = 8'(b);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] t_kexp(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    t  = {t_sbox(k[23:16]), t_sbox(k[15:8]), t_sbox(k[7:0]), t_sbox(k[31:24])};
    w0 = k[127:96] ^ t ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] t_round(input logic [127:0] s, input logic [127:0] k, input bit last);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = t_sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
    if (!last)
      for (int c = 0; c < 4; c++) begin
        {a0, a1, a2, a3} = o[127-32*c -: 32];
        o[127-32*c -: 32] = {t_xt(a0) ^ t_xt(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ t_xt(a1) ^ t_xt(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ t_xt(a2) ^ t_xt(a3) ^ a3,
                             t_xt(a0) ^ a0 ^ a1 ^ a2 ^ t_xt(a3)};
      end
    return o ^ k;
  endfunction

  function automatic logic [127:0] t_encrypt(input logic [127:0] k, input logic [127:0] p);
    logic [127:0] s, rk;
    logic [7:0] rc;
    s = p ^ k; rk = k; rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      rk = t_kexp(rk, rc);
      rc = t_xt(rc);
      s  = t_round(s, rk, r == 10);
    end
    return s;
  endfunction

  // Each done pops one expected block and its acceptance cycle.
  always @(negedge clk) begin
    if (!rst && done) begin
      check("done_pulse", 128'(done_prev), 128'd0);
      check("done_expected", 128'(exp_q.size() != 0), 128'd1);
      if (exp_q.size() != 0) begin
        check("plaintext", plaintext, exp_q.pop_front());
        check("latency", 128'(cyc - acc_q.pop_front()), 128'd21);
      end
      done_cnt++;
      last_done = cyc;
    end
    done_prev = done;
  end

  // Called at a negedge; the following posedge samples start.
  task automatic drive(input logic [127:0] ct, input logic [127:0] k, input logic [127:0] p, input bit accept);
    start = 1'b1; ciphertext = ct; key = k;
    if (accept) begin
      exp_q.push_back(p);
      acc_q.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    ciphertext = {$urandom, $urandom, $urandom, $urandom};
    key = ~k;
  endtask

  task automatic issue(input logic [127:0] ct, input logic [127:0] k, input logic [127:0] p);
    @(negedge clk);
    drive(ct, k, p, 1'b1);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 100 && done_cnt < target; i++) @(posedge clk);
    check("wait_done", 128'(done_cnt >= target), 128'd1);
  endtask

  initial begin
    int d1, n;
    logic [127:0] lct;

    repeat (3) @(posedge clk);
    #1;
    check("rst_plaintext", plaintext, 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(C1_CT, C1_K, C1_PT);
    wait_done(1);
    issue(B_CT, B_K, B_PT);
    wait_done(2);

    // Second start lands in the done cycle of the first.
    issue(C1_CT, C1_K, C1_PT);
    d1 = cyc;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      d1 = cyc;
      if (done) break;
    end
    drive(B_CT, B_K, B_PT, 1'b1);
    check("b2b_busy", 128'(busy), 128'd1);
    wait_done(4);
    // Start is sampled on the edge closing the done cycle, then 21 cycles of latency.
    check("b2b_gap", 128'(last_done - d1), 128'd22);

    issue(E_CT, B_K, E_PT);
    repeat (4) @(negedge clk);
    check("busy_mid", 128'(busy), 128'd1);
    drive(C1_CT, C1_K, 128'd0, 1'b0);
    wait_done(5);

    issue(C1_CT, C1_K, C1_PT);
    repeat (11) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_plaintext", plaintext, 128'd0);
    check("rst_mid_busy", 128'(busy), 128'd0);
    exp_q.delete();
    acc_q.delete();
    n = done_cnt;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(posedge clk);
    check("no_done_after_rst", 128'(done_cnt), 128'(n));
    issue(C1_CT, C1_K, C1_PT);
    wait_done(n + 1);

    check("enc_model", t_encrypt(C1_K, C1_PT), C1_CT);
    lct = t_encrypt(L_K, L_PT);
    issue(lct, L_K, L_PT);
    wait_done(n + 2);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
